gpio_port: RTL and testbench
============================

# gpio_port

Parametrised GPIO port; the successor to the plain output-latch GPIO. It sits on the 8-bit CPU bus behind the address decoder and provides:
- Per-pin direction control.
- Synchronised input readback.
- Atomic set/clear/toggle of output bits.
- Rising-edge interrupt capture with a single level IRQ line to the CPU.

## Interface
Parameters:
- NUM_PINS, 8, number of pins, legal range 1..8. Register bits at or above NUM_PINS read 0 and ignore writes.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- cs  input  1  register access strobe from the address decoder; one access per cycle with cs high
- we  input  1  1 = write, 0 = read; qualified by cs
- addr  input  3  register select
- data_in  input  8  CPU write data
- data_out  output  8  registered read data
- pins_in  input  NUM_PINS  asynchronous pad inputs
- pins_out  output  NUM_PINS  output data to pads (the OUT register)
- pins_oe  output  NUM_PINS  pad output enable (the DIR register; 1 = drive)
- irq  output  1  level interrupt, active-high

## Operation
Register map (addr):
- 0 OUT, R/W.
- 1 DIR, R/W.
- 2 IN, RO; reads the synchronised pins_in. Writes are ignored.
- 3 IEN, R/W; rising-edge interrupt enable.
- 4 STAT, R/W1C; edge-captured status.
- 5 SET, WO; OUT |= data. Reads 0.
- 6 CLR, WO; OUT &= ~data. Reads 0.
- 7 TGL, WO; OUT ^= data. Reads 0.

Input path:
- pins_in passes through a two-flop synchroniser (s1, s2), then a history flop (prev) that takes s2.
- edge = s2 & ~prev, evaluated per bit for all pins regardless of direction.

Status and interrupt:
- STAT update each cycle: STAT_next = (STAT & ~w1c_mask) | (edge & IEN).
- w1c_mask = data_in when writing addr 4, otherwise 0.
- An edge arriving in the same cycle as a W1C of that bit wins; the bit stays 1.
- Writing IEN does not clear STAT. Clearing an IEN bit leaves its STAT bit set.
- irq = |(STAT & IEN), decoded combinationally from registers.

Reads:
- When cs & ~we, data_out loads the selected register on the next edge.
- data_out holds its value when there is no read.
- Reads have no side effects.

Reset values:
- OUT, DIR, IEN, STAT, s1, s2, prev, data_out = 0.
- Therefore pins_out = 0, pins_oe = 0, irq = 0.
- Because IEN = 0 after reset, a pin already high at reset never sets STAT.
- Reset asserted mid-operation overrides any concurrent write in that cycle.

## Timing
- Write: data presented with cs & we in cycle N takes effect at edge N+1. pins_out, pins_oe and IEN change at that edge.
- Read: data_out is valid the cycle after the cs read cycle, giving 1-cycle read latency.
- Input: a pins_in change sampled at edge N is visible in s2, and in IN reads, after edge N+1.
- Edge capture: STAT sets at edge N+2, and irq rises in the same cycle. Total pin-to-irq latency is 3 edges.
- Pulses shorter than one clk period may be missed. Each rising edge of a pin held high sets STAT once only.

## Configuration
- GPIO_PORT_IRQ_EN defined: IEN, STAT, edge detection and irq are implemented as described above.
- GPIO_PORT_IRQ_EN undefined:
  - No IEN, STAT or prev flops are built.
  - addr 3 and 4 read 0 and ignore writes.
  - irq is tied to 0.
  - The synchroniser and IN register remain.

## Test plan
- Reset then read all 8 addresses: every read returns 0x00, and pins_out = pins_oe = irq = 0.
- Write OUT=0xA5, SET 0x0A, CLR 0x21, TGL 0xFF: pins_out goes A5, AF, 8E, 71 on successive edges, and OUT reads 0x71.
- Drive pins_in=0x3C at edge N: an IN read issued at cycle N+2 returns 0x3C on data_out at N+3.
- IEN=0x01, then raise pins_in[0]: STAT=0x01 and irq=1 exactly 3 edges after the change. W1C 0x01 clears irq on the next edge. Holding the pin high does not reassert.
- Rising edge on pin 0 coincident with a W1C 0x01 of STAT: STAT[0] remains 1 and irq stays 1.
- With GPIO_PORT_IRQ_EN undefined, repeat the IEN/edge test: irq stays 0, and addr 3/4 read 0x00.

Source files
------------

// File: rtl/gpio_port.sv
// gpio_port: CPU-bus GPIO with direction, synchronised input, set/clear/toggle and rising-edge IRQ.
// Define GPIO_PORT_IRQ_EN to build IEN/STAT/edge capture; otherwise irq is 0 and addr 3/4 read 0.
module gpio_port #(
  parameter int NUM_PINS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic                we,
  input  logic [2:0]          addr,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  input  logic [NUM_PINS-1:0] pins_in,
  output logic [NUM_PINS-1:0] pins_out,
  output logic [NUM_PINS-1:0] pins_oe,
  output logic                irq
);
  logic [NUM_PINS-1:0] out_r, dir_r, s1, s2, wd;
  logic [7:0] rd, ien_rd, stat_rd;
  logic wr;
  assign wr = cs & we;
  assign wd = data_in[NUM_PINS-1:0];
  assign pins_out = out_r;
  assign pins_oe = dir_r;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r <= '0;
      dir_r <= '0;
      s1 <= '0;
      s2 <= '0;
      data_out <= '0;
    end else begin
      s1 <= pins_in;
      s2 <= s1;
      if (wr) begin
        out_r <= addr == 3'd0 ? wd :
                 addr == 3'd5 ? out_r | wd :
                 addr == 3'd6 ? out_r & ~wd :
                 addr == 3'd7 ? out_r ^ wd : out_r;
        if (addr == 3'd1) dir_r <= wd;
      end
      if (cs && !we) data_out <= rd;
    end
  end
`ifdef GPIO_PORT_IRQ_EN
  logic [NUM_PINS-1:0] prev, ien, stat;
  // new edges are OR'd in after the W1C mask so a coincident edge wins
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
      ien <= '0;
      stat <= '0;
    end else begin
      prev <= s2;
      if (wr && addr == 3'd3) ien <= wd;
      stat <= (stat & ~((wr && addr == 3'd4) ? wd : '0)) | (s2 & ~prev & ien);
    end
  end
  assign irq = |(stat & ien);
  assign ien_rd = 8'(ien);
  assign stat_rd = 8'(stat);
`else
  assign irq = 1'b0;
  assign ien_rd = 8'h00;
  assign stat_rd = 8'h00;
`endif
  always_comb begin
    rd = addr == 3'd0 ? 8'(out_r) :
         addr == 3'd1 ? 8'(dir_r) :
         addr == 3'd2 ? 8'(s2) :
         addr == 3'd3 ? ien_rd :
         addr == 3'd4 ? stat_rd : 8'h00;
  end
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed scoreboard bench for gpio_port; adapts expectations to GPIO_PORT_IRQ_EN.
module tb_gpio_port;
`ifdef GPIO_PORT_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, cs = 1'b0, we = 1'b0, irq;
  logic [2:0] addr = '0;
  logic [7:0] data_in = '0, data_out, pins_in = '0, pins_out, pins_oe;
  logic [7:0] sb[$];
  int checks = 0, errors = 0;

  gpio_port #(.NUM_PINS(8)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .pins_in(pins_in), .pins_out(pins_out), .pins_oe(pins_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h with no expected value queued", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; data_in = d;
    cyc();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
    cs = 1'b1; we = 1'b0; addr = a;
    push(exp);
    cyc();
    cs = 1'b0;
    check(tag, data_out);
  endtask

  task automatic chk_irq(input logic e, input string tag);
    push({7'd0, e});
    check(tag, {7'd0, irq});
  endtask

  initial begin
    repeat (2) cyc();
    reset = 1'b0;
    push(8'h00); check("rst_pins_out", pins_out);
    push(8'h00); check("rst_pins_oe", pins_oe);
    chk_irq(1'b0, "rst_irq");
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, $sformatf("rst_rd%0d", i));
    wr(3'd0, 8'hA5); push(8'hA5); check("out_wr", pins_out);
    wr(3'd5, 8'h0A); push(8'hAF); check("out_set", pins_out);
    wr(3'd6, 8'h21); push(8'h8E); check("out_clr", pins_out);
    wr(3'd7, 8'hFF); push(8'h71); check("out_tgl", pins_out);
    rd(3'd0, 8'h71, "rd_out");
    cyc(); push(8'h71); check("rd_hold", data_out);
    rd(3'd7, 8'h00, "rd_tgl_zero");
    wr(3'd1, 8'h5A); push(8'h5A); check("dir_oe", pins_oe);
    rd(3'd1, 8'h5A, "rd_dir");
    wr(3'd2, 8'hFF);
    rd(3'd2, 8'h00, "in_ro");
    pins_in = 8'h3C;
    cyc();
    rd(3'd2, 8'h00, "in_early");
    rd(3'd2, 8'h3C, "in_sync");
    pins_in = 8'h00;
    repeat (4) cyc();
    wr(3'd3, 8'h01);
    rd(3'd3, IRQ ? 8'h01 : 8'h00, "rd_ien");
    pins_in = 8'h01;
    cyc(); chk_irq(1'b0, "irq_lat1");
    cyc(); chk_irq(1'b0, "irq_lat2");
    cyc(); chk_irq(IRQ, "irq_lat3");
    rd(3'd4, IRQ ? 8'h01 : 8'h00, "rd_stat");
    wr(3'd4, 8'h01); chk_irq(1'b0, "w1c_clear");
    repeat (3) cyc();
    chk_irq(1'b0, "held_no_reassert");
    rd(3'd4, 8'h00, "stat_held_zero");
    pins_in = 8'h00;
    repeat (3) cyc();
    pins_in = 8'h01;
    repeat (3) cyc();
    chk_irq(IRQ, "irq_second_edge");
    pins_in = 8'h00;
    repeat (3) cyc();
    pins_in = 8'h01;
    cyc(); cyc();
    wr(3'd4, 8'h01); chk_irq(IRQ, "edge_beats_w1c");
    rd(3'd4, IRQ ? 8'h01 : 8'h00, "stat_after_race");
    wr(3'd3, 8'h00); chk_irq(1'b0, "ien_clear_irq");
    rd(3'd4, IRQ ? 8'h01 : 8'h00, "ien_clear_keeps_stat");
    wr(3'd4, 8'hFF);
    rd(3'd4, 8'h00, "stat_w1c_all");
    reset = 1'b1; cs = 1'b1; we = 1'b1; addr = 3'd1; data_in = 8'hFF;
    cyc();
    reset = 1'b0; cs = 1'b0; we = 1'b0;
    push(8'h00); check("rst_mid_oe", pins_oe);
    push(8'h00); check("rst_mid_out", pins_out);
    push(8'h00); check("rst_mid_dout", data_out);
    chk_irq(1'b0, "rst_mid_irq");
    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected %0d", sb.size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
